// File: rtl/cache_way_select.sv
// Tag lookup and way selection for one set-associative cache level; picks hit/invalid/LRU way,
// hands it to update_LRU and writes the returned counter back while aging the rest of the set.
module cache_way_select #(
   parameter int unsigned WAYS  = 4,
   parameter int unsigned SETS  = 16384,
   parameter int unsigned TAG_W = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [$clog2(SETS)-1:0] req_set,
   input  logic [TAG_W-1:0]        req_tag,
   input  logic                    req_inv,
   output logic [WAYS-1:0]         block_sel,
   output logic [$clog2(WAYS)-1:0] LRU_b,
   output logic                    sel_valid,
   input  logic [$clog2(WAYS)-1:0] up_LRU_b,
   output logic                    rsp_valid,
   output logic                    rsp_hit,
   output logic [$clog2(WAYS)-1:0] rsp_way,
   output logic                    rsp_evict,
   output logic [TAG_W-1:0]        rsp_evict_tag
);
   localparam int unsigned CW = $clog2(WAYS);
   localparam int unsigned SW = $clog2(SETS);

   typedef enum logic [2:0] {StInit, StIdle, StScan, StUpdate, StResp} state_e;
   state_e state_q, state_d;

   logic [WAYS-1:0]    valid_mem [SETS];
   logic [WAYS*CW-1:0] cnt_mem   [SETS];
   logic [TAG_W-1:0]   tag_mem   [SETS][WAYS];

   logic [SW-1:0]    set_ptr_q;
   logic [SW-1:0]    set_q;
   logic [TAG_W-1:0] tag_q;
   logic             inv_q;
   logic [CW-1:0]    scan_q;
   logic             hit_found_q, inv_found_q;
   logic [CW-1:0]    hit_way_q, inv_way_q, lru_way_q;

   logic             rsp_hit_q, rsp_evict_q;
   logic [CW-1:0]    rsp_way_q;
   logic [TAG_W-1:0] rsp_evict_tag_q;

   logic             scan_valid;
   logic [TAG_W-1:0] scan_tag;
   logic [CW-1:0]    scan_cnt;
   logic [WAYS*CW-1:0] set_cnt, aged_cnt, init_cnt;
   logic [CW-1:0]    chosen, lru_b;
   logic             evict;

   always_comb begin
      scan_valid = valid_mem[set_q][scan_q];
      scan_tag   = tag_mem[set_q][scan_q];
      set_cnt    = cnt_mem[set_q];
      scan_cnt   = set_cnt[scan_q*CW +: CW];
   end

   always_comb begin
      chosen = lru_way_q;
      if (hit_found_q) begin
         chosen = hit_way_q;
      end else if (inv_found_q) begin
         chosen = inv_way_q;
      end
      evict = !hit_found_q && !inv_found_q && !inv_q;
      lru_b = set_cnt[chosen*CW +: CW];
   end

   // Chosen way takes the new counter; ways more recent than it slide down by one.
   always_comb begin
      aged_cnt = set_cnt;
      init_cnt = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         init_cnt[w*CW +: CW] = CW'(w);
         if (CW'(w) == chosen) begin
            aged_cnt[w*CW +: CW] = up_LRU_b;
         end else if (set_cnt[w*CW +: CW] > lru_b) begin
            aged_cnt[w*CW +: CW] = set_cnt[w*CW +: CW] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StInit;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StInit:   if (set_ptr_q == SW'(SETS - 1)) state_d = StIdle;
         StIdle:   if (req_valid) state_d = StScan;
         StScan:   if (scan_q == CW'(WAYS - 1)) state_d = StUpdate;
         StUpdate: state_d = StResp;
         StResp:   state_d = StIdle;
         default:  state_d = StInit;
      endcase
   end

   always_comb begin
      req_ready     = (state_q == StIdle);
      sel_valid     = (state_q == StUpdate) && !inv_q;
      block_sel     = sel_valid ? (WAYS'(1) << chosen) : '0;
      LRU_b         = sel_valid ? lru_b : '0;
      rsp_valid     = (state_q == StResp);
      rsp_hit       = rsp_hit_q;
      rsp_way       = rsp_way_q;
      rsp_evict     = rsp_evict_q;
      rsp_evict_tag = rsp_evict_tag_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         set_ptr_q       <= '0;
         set_q           <= '0;
         tag_q           <= '0;
         inv_q           <= 1'b0;
         scan_q          <= '0;
         hit_found_q     <= 1'b0;
         inv_found_q     <= 1'b0;
         hit_way_q       <= '0;
         inv_way_q       <= '0;
         lru_way_q       <= '0;
         rsp_hit_q       <= 1'b0;
         rsp_way_q       <= '0;
         rsp_evict_q     <= 1'b0;
         rsp_evict_tag_q <= '0;
      end else begin
         case (state_q)
            StInit: set_ptr_q <= set_ptr_q + 1'b1;
            StIdle: begin
               if (req_valid) begin
                  set_q       <= req_set;
                  tag_q       <= req_tag;
                  inv_q       <= req_inv;
                  scan_q      <= '0;
                  hit_found_q <= 1'b0;
                  inv_found_q <= 1'b0;
                  hit_way_q   <= '0;
                  inv_way_q   <= '0;
                  lru_way_q   <= '0;
               end
            end
            StScan: begin
               scan_q <= scan_q + 1'b1;
               if (!hit_found_q && scan_valid && (scan_tag == tag_q)) begin
                  hit_found_q <= 1'b1;
                  hit_way_q   <= scan_q;
               end
               if (!inv_found_q && !scan_valid) begin
                  inv_found_q <= 1'b1;
                  inv_way_q   <= scan_q;
               end
               if (scan_cnt == '0) lru_way_q <= scan_q;
            end
            StUpdate: begin
               rsp_hit_q       <= hit_found_q;
               rsp_way_q       <= (inv_q && !hit_found_q) ? '0 : chosen;
               rsp_evict_q     <= evict;
               rsp_evict_tag_q <= evict ? tag_mem[set_q][chosen] : '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == StInit) begin
            valid_mem[set_ptr_q] <= '0;
            cnt_mem[set_ptr_q]   <= init_cnt;
         end else if (state_q == StUpdate) begin
            if (!inv_q) begin
               cnt_mem[set_q] <= aged_cnt;
               if (!hit_found_q) begin
                  tag_mem[set_q][chosen]   <= tag_q;
                  valid_mem[set_q][chosen] <= 1'b1;
               end
            end else if (hit_found_q) begin
               valid_mem[set_q][hit_way_q] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cache_way_select.sv
// Directed bench for cache_way_select: a 4-way and an 8-way instance, update_LRU modelled as
// "chosen way becomes MRU".
module tb_cache_way_select;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, v, use8;
   logic [3:0] rset;
   logic [11:0] rtag;
   logic rinv;

   logic v4, rdy4, sv4, rv4, rh4, re4;
   logic [3:0] bs4;
   logic [1:0] lru4, up4, rw4;
   logic [11:0] et4;
   logic v8, rdy8, sv8, rv8, rh8, re8;
   logic [7:0] bs8;
   logic [2:0] lru8, up8, rw8;
   logic [11:0] et8;

   logic rdy, sv, rv, rh, re;
   logic [7:0] bs;
   logic [2:0] lru_o, rw;
   logic [11:0] et;

   assign v4  = v && !use8;
   assign v8  = v && use8;
   assign up4 = 2'd3;
   assign up8 = 3'd7;

   cache_way_select #(.WAYS(4), .SETS(16), .TAG_W(12)) dut4 (
      .clk(clk), .rst(rst), .req_valid(v4), .req_ready(rdy4), .req_set(rset), .req_tag(rtag),
      .req_inv(rinv), .block_sel(bs4), .LRU_b(lru4), .sel_valid(sv4), .up_LRU_b(up4),
      .rsp_valid(rv4), .rsp_hit(rh4), .rsp_way(rw4), .rsp_evict(re4), .rsp_evict_tag(et4)
   );

   cache_way_select #(.WAYS(8), .SETS(16), .TAG_W(12)) dut8 (
      .clk(clk), .rst(rst), .req_valid(v8), .req_ready(rdy8), .req_set(rset), .req_tag(rtag),
      .req_inv(rinv), .block_sel(bs8), .LRU_b(lru8), .sel_valid(sv8), .up_LRU_b(up8),
      .rsp_valid(rv8), .rsp_hit(rh8), .rsp_way(rw8), .rsp_evict(re8), .rsp_evict_tag(et8)
   );

   always_comb begin
      if (use8) begin
         rdy = rdy8; sv = sv8; rv = rv8; rh = rh8; re = re8;
         bs = bs8; lru_o = lru8; rw = rw8; et = et8;
      end else begin
         rdy = rdy4; sv = sv4; rv = rv4; rh = rh4; re = re4;
         bs = {4'b0, bs4}; lru_o = {1'b0, lru4}; rw = {1'b0, rw4}; et = et4;
      end
   end

   int total = 0;
   int bad = 0;
   int r_hit, r_way, r_evict, r_etag, r_lat, r_sel, r_lru, r_saw;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, got, exp);
      end
   endtask

   // One request on the selected instance; returns when rsp_valid is seen (sampled at negedge).
   task automatic access(input int s, input int t, input bit inv);
      int n;
      n = 0;
      while (!rdy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", rdy, 1'b1);
      rset = 4'(s);
      rtag = 12'(t);
      rinv = inv;
      v = 1'b1;
      @(negedge clk);
      v = 1'b0;
      r_lat = 1; r_saw = 0; r_sel = 0; r_lru = 0;
      while (!rv && r_lat < 30) begin
         if (sv) begin
            r_saw = 1;
            r_sel = int'(bs);
            r_lru = int'(lru_o);
         end
         @(negedge clk);
         r_lat++;
      end
      check("rsp_valid", rv, 1'b1);
      r_hit = int'(rh); r_way = int'(rw); r_evict = int'(re); r_etag = int'(et);
   endtask

   task automatic wait_init(input string name);
      int n;
      n = 0;
      while (!rdy4 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(name, n, 16);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int n;
      use8 = 1'b0; v = 1'b0; rset = '0; rtag = '0; rinv = 1'b0; rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready_sel", {rdy4, sv4, bs4, lru4}, 0);
      check("rst_rsp", {rv4, rh4, rw4, re4, et4}, 0);
      check("rst_8way", {rdy8, sv8, bs8, lru8, rv8, rh8, rw8, re8, et8}, 0);
      rst = 1'b0;
      wait_init("init_len");

      // First request after INIT: plain allocate into way 0.
      access(3, 'h0AB, 1'b0);
      check("first_lat", r_lat, 6);
      check("first_rsp", {r_hit[0], r_way[1:0], r_evict[0]}, 0);
      check("first_sel", {r_sel[3:0], r_lru[1:0]}, {4'b0001, 2'd0});
      @(negedge clk);
      check("rsp_pulse", {rv4, rdy4}, 2'b01);

      // Fill set 5.
      for (int i = 0; i < 4; i++) begin
         access(5, i + 1, 1'b0);
         check("fill_way", r_way, i);
         check("fill_hit_evict", {r_hit[0], r_evict[0]}, 0);
      end
      // Counters now {0,1,2,3}; hit way 1 -> {0,3,1,2}.
      access(5, 2, 1'b0);
      check("hit_rsp", {r_hit[0], r_way[1:0], r_evict[0]}, {1'b1, 2'd1, 1'b0});
      check("hit_sel", {r_sel[3:0], r_lru[1:0]}, {4'b0010, 2'd1});
      // Evict way 0 (cnt 0) -> {3,2,0,1}.
      access(5, 5, 1'b0);
      check("evict_rsp", {r_hit[0], r_way[1:0], r_evict[0]}, {1'b0, 2'd0, 1'b1});
      check("evict_tag", r_etag, 'h001);
      check("evict_lru", r_lru, 0);
      // Invalidate tag 3 (way 2).
      access(5, 3, 1'b1);
      check("inv_rsp", {r_hit[0], r_way[1:0], r_evict[0]}, {1'b1, 2'd2, 1'b0});
      check("inv_no_sel", r_saw, 0);
      // Miss reuses freed way 2; counters unchanged by invalidate so LRU_b=0 -> {2,1,3,0}.
      access(5, 7, 1'b0);
      check("realloc_rsp", {r_hit[0], r_way[1:0], r_evict[0]}, {1'b0, 2'd2, 1'b0});
      check("realloc_sel", {r_sel[3:0], r_lru[1:0]}, {4'b0100, 2'd0});
      access(5, 8, 1'b0);
      check("age_evict", {r_way[1:0], r_evict[0]}, {2'd3, 1'b1});
      check("age_evict_tag", r_etag, 'h004);
      access(5, 'h99, 1'b1);
      check("inv_miss", {r_hit[0], r_way[1:0], r_evict[0]}, 0);
      access(5, 5, 1'b0);
      check("hit_before_rst", {r_hit[0], r_way[1:0]}, {1'b1, 2'd0});

      // Abort on scan cycle 2.
      n = 0;
      while (!rdy4 && n < 50) begin
         @(negedge clk);
         n++;
      end
      rset = 4'd5; rtag = 12'h005; rinv = 1'b0; v = 1'b1;
      @(negedge clk);
      v = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         if (rv4) n++;
         @(negedge clk);
      end
      check("abort_no_rsp", n, 0);
      check("abort_ready", rdy4, 1'b1);
      for (int s = 0; s < 16; s++) begin
         access(s, (s == 5) ? 5 : 'h0AB, 1'b0);
         check("post_rst_invalid", {r_hit[0], r_way[1:0], r_evict[0]}, 0);
      end

      // 8-way: fill set 0, then 8 misses evict in way order.
      use8 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         access(0, 'h10 + i, 1'b0);
         check("fill8_way", {r_way[2:0], r_evict[0]}, {3'(i), 1'b0});
      end
      check("lat8", r_lat, 10);
      for (int i = 0; i < 8; i++) begin
         access(0, 'h20 + i, 1'b0);
         check("evict8_way", {r_hit[0], r_way[2:0], r_evict[0]}, {1'b0, 3'(i), 1'b1});
         check("evict8_tag", r_etag, 'h10 + i);
         check("evict8_sel", r_sel, 1 << i);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
